enc_unbinder_pack: RTL

ENC_UNBINDER_PACK -- requirements
Module: enc_unbinder_pack

---
 rtl/enc_unbinder_pack.sv | 117 +++++++++++
 1 files changed

// File: rtl/enc_unbinder_pack.sv
// Hypervector unbinder: undoes the binder's per-feature rotate-left.
// One HV_DIM-bit rotator is shared across features, one feature per enabled cycle.
//
//   state  | meaning
//   IDLE   | waiting for an input set, in_ready high
//   UNBIND | rotating buffered feature idx into the output buffer
//   DONE   | recovered set presented, waiting for out_ready
module enc_unbinder_pack #(
  parameter int HV_DIM          = 1024,
  parameter int FEATURES_PER_CC = 6,
  parameter int SHIFT_W         = 10,
  parameter logic [FEATURES_PER_CC*SHIFT_W-1:0] SHIFTS = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1],
  input  logic              en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] level_hv [0:FEATURES_PER_CC-1],
  output logic              busy
);

  localparam int IDX_W = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNBIND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [HV_DIM-1:0]  r_in_buf  [0:FEATURES_PER_CC-1];
  logic [HV_DIM-1:0]  r_out_buf [0:FEATURES_PER_CC-1];
  logic [SHIFT_W-1:0] w_shift_tab [0:FEATURES_PER_CC-1];
  logic [SHIFT_W-1:0] w_shift;
  logic [HV_DIM-1:0]  w_sel;
  logic [2*HV_DIM-1:0] w_dbl;
  logic [HV_DIM-1:0]  w_rot;
  logic               w_last;
  logic               w_step;

  // Shift amounts are fixed at elaboration; reduce them mod HV_DIM once here.
  for (genvar gi = 0; gi < FEATURES_PER_CC; gi++) begin : g_shift
    localparam int unsigned SH_MOD =
      int'(SHIFTS[gi*SHIFT_W +: SHIFT_W]) % HV_DIM;
    assign w_shift_tab[gi] = SHIFT_W'(SH_MOD);
  end

  assign w_last = (r_idx == IDX_W'(FEATURES_PER_CC-1));
  assign w_step = (r_state == S_UNBIND) && en;

  // Shared rotator: rotate-right by s, taken from a doubled copy of the word.
  always_comb begin
    w_sel   = r_in_buf[r_idx];
    w_shift = w_shift_tab[r_idx];
    w_dbl   = {w_sel, w_sel};
    w_rot   = HV_DIM'(w_dbl >> w_shift);
  end

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_UNBIND;
      S_UNBIND: if (en && w_last) w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:   in_ready = 1'b1;
      S_UNBIND: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default:  in_ready = 1'b0;
    endcase
  end

  // Buffers and feature index; idx saturates at the last feature.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_idx <= '0;
      for (int i = 0; i < FEATURES_PER_CC; i++) begin
        r_in_buf[i]  <= '0;
        r_out_buf[i] <= '0;
      end
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_idx <= '0;
      for (int i = 0; i < FEATURES_PER_CC; i++) r_in_buf[i] <= shifted_hv[i];
    end else if (w_step) begin
      r_out_buf[r_idx] <= w_rot;
      if (!w_last) r_idx <= r_idx + 1'b1;
    end
  end

  assign level_hv = r_out_buf;

endmodule
